mem_wb_capture: RTL

//  MEM/WB boundary stage: registers each retiring MEM-stage result and tracks the outstanding

---
 rtl/mem_wb_capture.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/mem_wb_capture.sv
// MEM/WB boundary: holds the in-flight dmem request, stalls MEM until dmem_resp,
// aligns load data and emits one writeback pulse per retired instruction.
module mem_wb_capture #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             mem_valid,
   input  logic [2:0]       mem_funct3,
   input  logic [4:0]       mem_rd_s,
   input  logic             mem_regf_we,
   input  logic [31:0]      mem_wb_data,
   input  logic [31:0]      mem_addr,
   input  logic [3:0]       mem_rmask,
   input  logic [3:0]       mem_wmask,
   input  logic             dmem_resp,
   input  logic [31:0]      dmem_rdata,
   output logic             freeze_stall,
   output logic             wb_valid,
   output logic             wb_we,
   output logic [4:0]       wb_rd_s,
   output logic [31:0]      wb_rd_v,
   output logic             resp_err,
   output logic [CNT_W-1:0] stall_cycles
);

   typedef enum logic {IDLE, WAIT} state_t;

   state_t      state, state_next;
   logic [2:0]  pend_funct3;
   logic [4:0]  pend_rd_s;
   logic        pend_regf_we;
   logic [1:0]  pend_off;
   logic        pend_load;

   // One-entry deferral slot: a non-memory op accepted on the same edge a
   // writeback is already being emitted retires one cycle later.
   logic        slot_valid;
   logic        slot_we;
   logic [4:0]  slot_rd_s;
   logic [31:0] slot_rd_v;

   logic        complete, accept, is_mem, take_nonmem;
   logic [7:0]  byte_v;
   logic [15:0] half_v;
   logic [31:0] load_v;
   logic        unused_addr;

   assign unused_addr  = &{1'b0, mem_addr[31:2]};
   assign complete     = (state == WAIT) && dmem_resp;
   assign freeze_stall = (state == WAIT) && !dmem_resp;
   assign accept       = mem_valid && !freeze_stall;
   assign is_mem       = (mem_rmask != 4'd0) || (mem_wmask != 4'd0);
   assign take_nonmem  = accept && !is_mem;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      if (accept && is_mem) state_next = WAIT;
      else if (complete)    state_next = IDLE;
   end

   always_comb begin
      byte_v = dmem_rdata[7:0];
      case (pend_off)
         2'd0: byte_v = dmem_rdata[7:0];
         2'd1: byte_v = dmem_rdata[15:8];
         2'd2: byte_v = dmem_rdata[23:16];
         2'd3: byte_v = dmem_rdata[31:24];
         default: byte_v = dmem_rdata[7:0];
      endcase
      half_v = pend_off[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
      case (pend_funct3)
         3'b000:  load_v = {{24{byte_v[7]}}, byte_v};
         3'b001:  load_v = {{16{half_v[15]}}, half_v};
         3'b010:  load_v = dmem_rdata;
         3'b100:  load_v = {24'd0, byte_v};
         3'b101:  load_v = {16'd0, half_v};
         default: load_v = 32'd0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wb_valid     <= 1'b0;
         wb_we        <= 1'b0;
         wb_rd_s      <= 5'd0;
         wb_rd_v      <= 32'd0;
         slot_valid   <= 1'b0;
         slot_we      <= 1'b0;
         slot_rd_s    <= 5'd0;
         slot_rd_v    <= 32'd0;
         pend_funct3  <= 3'd0;
         pend_rd_s    <= 5'd0;
         pend_regf_we <= 1'b0;
         pend_off     <= 2'd0;
         pend_load    <= 1'b0;
         resp_err     <= 1'b0;
         stall_cycles <= '0;
      end else begin
         wb_valid <= 1'b0;
         if (complete) begin
            wb_valid <= 1'b1;
            if (pend_load) begin
               wb_we   <= pend_regf_we && (pend_rd_s != 5'd0);
               wb_rd_s <= pend_rd_s;
               wb_rd_v <= load_v;
            end else begin
               wb_we   <= 1'b0;
               wb_rd_s <= 5'd0;
               wb_rd_v <= 32'd0;
            end
         end else if (slot_valid) begin
            wb_valid <= 1'b1;
            wb_we    <= slot_we;
            wb_rd_s  <= slot_rd_s;
            wb_rd_v  <= slot_rd_v;
         end else if (take_nonmem) begin
            wb_valid <= 1'b1;
            wb_we    <= mem_regf_we && (mem_rd_s != 5'd0);
            wb_rd_s  <= mem_rd_s;
            wb_rd_v  <= mem_wb_data;
         end

         slot_valid <= take_nonmem && (complete || slot_valid);
         if (take_nonmem) begin
            slot_we   <= mem_regf_we && (mem_rd_s != 5'd0);
            slot_rd_s <= mem_rd_s;
            slot_rd_v <= mem_wb_data;
         end

         if (accept && is_mem) begin
            pend_funct3  <= mem_funct3;
            pend_rd_s    <= mem_rd_s;
            pend_regf_we <= mem_regf_we;
            pend_off     <= mem_addr[1:0];
            pend_load    <= (mem_rmask != 4'd0);
         end

         if (dmem_resp && (state == IDLE)) resp_err <= 1'b1;
         if (freeze_stall && (stall_cycles != {CNT_W{1'b1}}))
            stall_cycles <= stall_cycles + 1'b1;
      end
   end

endmodule
